// File: rtl/painterengine_gpu_dma_defs.sv
// Shared definitions for the GPU DMA reader and writer.
// Holds the state encodings, the AXI4 constants used on the memory side, the 4 KB
// boundary constant and the burst-size helper.
package painterengine_gpu_dma_defs;

  typedef enum logic [7:0] {
    StInit  = 8'h00,
    StAddr  = 8'h01,
    StData  = 8'h02,
    StDone  = 8'h03,
    StError = 8'h04
  } dma_state_e;

  localparam logic [1:0]  AxiRespOkay  = 2'b00;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam logic [2:0]  AxiSize4B    = 3'b010;
  localparam logic [31:0] Boundary4K   = 32'd4096;

  // Beats for the next burst: the smallest of the words left, the burst cap and the
  // words remaining before the next 4 KB page (a burst must not cross a page).
  function automatic logic [8:0] burst_beats(input logic [31:0]  remaining,
                                             input logic [31:0]  addr,
                                             input int unsigned max_beats);
    logic [31:0] to_boundary;
    logic [31:0] beats;
    to_boundary = (Boundary4K - {20'd0, addr[11:0]}) >> 2;
    beats       = remaining;
    if (beats > max_beats)   beats = max_beats;
    if (beats > to_boundary) beats = to_boundary;
    return beats[8:0];
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches a word-aligned region and pushes each word into the GPU
// copy FIFO. One transfer runs per reset release; done/error are sticky until reset.
// Ports:
//   i_wire_clock, i_wire_resetn      clock, async active-low reset (starts a transfer)
//   i_wire_address, i_wire_length    region start / byte count, sampled on first edge
//   o_wire_done, o_wire_error        sticky completion / failure flags
//   o_wire_m_axi_ar*, i_wire_m_axi_arready   AXI read address channel
//   i_wire_m_axi_r*, o_wire_m_axi_rready     AXI read data channel
//   o_wire_fifo_wr_en/_data, i_wire_fifo_full  FIFO push side
//   o_wire_state                     debug view of the FSM state
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_defs::*;
#(
  parameter int unsigned MAX_BURST_BEATS = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_m_axi_araddr,
  output logic [7:0]  o_wire_m_axi_arlen,
  output logic [2:0]  o_wire_m_axi_arsize,
  output logic [1:0]  o_wire_m_axi_arburst,
  output logic        o_wire_m_axi_arvalid,
  input  logic        i_wire_m_axi_arready,
  input  logic [31:0] i_wire_m_axi_rdata,
  input  logic [1:0]  i_wire_m_axi_rresp,
  input  logic        i_wire_m_axi_rlast,
  input  logic        i_wire_m_axi_rvalid,
  output logic        o_wire_m_axi_rready,
  output logic        o_wire_fifo_wr_en,
  output logic [31:0] o_wire_fifo_wr_data,
  input  logic        i_wire_fifo_full,
  output logic [31:0] o_wire_state
);

  dma_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;      // start of the next burst
  logic [31:0] rem_q, rem_d;        // words still to fetch
  logic [8:0]  beats_q, beats_d;    // size of the burst in flight
  logic [8:0]  cnt_q, cnt_d;        // beats left in the burst in flight
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        rready;
  logic        r_hs;
  logic        last_beat;
  logic [8:0]  beats_now;

  assign beats_now = burst_beats(rem_q, addr_q, MAX_BURST_BEATS);
  assign rready    = (state_q == StData) && !i_wire_fifo_full;
  assign r_hs      = rready && i_wire_m_axi_rvalid;
  assign last_beat = (cnt_q == 9'd1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    // Flags follow the terminal state by one edge and then stick.
    done_d    = done_q  || (state_q == StDone);
    error_d   = error_q || (state_q == StError);

    unique case (state_q)
      StInit: begin
        addr_d = i_wire_address;
        rem_d  = i_wire_length >> 2;
        if ((i_wire_address[1:0] != 2'b00) || (i_wire_length[1:0] != 2'b00)) begin
          state_d = StError;
        end else if (i_wire_length == 32'd0) begin
          state_d = StDone;
        end else begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        // First cycle computes and registers the AR fields; they then hold until accepted.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(beats_now - 9'd1);
          beats_d   = beats_now;
        end else if (i_wire_m_axi_arready) begin
          arvalid_d = 1'b0;
          cnt_d     = beats_q;
          state_d   = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          cnt_d = cnt_q - 9'd1;
          if ((i_wire_m_axi_rresp != AxiRespOkay) || (i_wire_m_axi_rlast != last_beat)) begin
            state_d = StError;
          end else if (last_beat) begin
            addr_d  = addr_q + {21'd0, beats_q, 2'b00};
            rem_d   = rem_q - {23'd0, beats_q};
            state_d = (rem_q == {23'd0, beats_q}) ? StDone : StAddr;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= StInit;
      addr_q    <= 32'd0;
      rem_q     <= 32'd0;
      beats_q   <= 9'd0;
      cnt_q     <= 9'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_m_axi_araddr  = araddr_q;
  assign o_wire_m_axi_arlen   = arlen_q;
  assign o_wire_m_axi_arsize  = AxiSize4B;
  assign o_wire_m_axi_arburst = AxiBurstIncr;
  assign o_wire_m_axi_arvalid = arvalid_q;
  assign o_wire_m_axi_rready  = rready;
  // Zero-latency push: the FIFO sees the beat in the same cycle as the R handshake.
  assign o_wire_fifo_wr_en    = r_hs;
  assign o_wire_fifo_wr_data  = r_hs ? i_wire_m_axi_rdata : 32'd0;
  assign o_wire_state         = {24'd0, state_q};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
module tb_painterengine_gpu_dma_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_len = 32'd0;
  logic        done, error;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        fifo_full = 1'b0;
  logic [31:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  // Scenario knobs, written only by the main sequence.
  int err_beat = -1;
  int stall_beat = -1;
  int stall_len = 0;
  bit ar_wait = 1'b0;

  // Observations, written only by the slave/monitor process.
  logic [31:0] pushes[$];
  logic [31:0] ar_addrs[$];
  logic [7:0]  ar_lens[$];
  int cyc = 0;
  int last_push_cyc = -1;
  int done_cyc = -1;
  int error_cyc = -1;
  int full_viol = 0;
  int ar_unstable = 0;
  int stall_seen = 0;
  bit arvalid_ever = 1'b0;

  painterengine_gpu_dma_reader #(.MAX_BURST_BEATS(16)) dut (
    .i_wire_clock         (clk),
    .i_wire_resetn        (rst_n),
    .i_wire_address       (i_addr),
    .i_wire_length        (i_len),
    .o_wire_done          (done),
    .o_wire_error         (error),
    .o_wire_m_axi_araddr  (araddr),
    .o_wire_m_axi_arlen   (arlen),
    .o_wire_m_axi_arsize  (arsize),
    .o_wire_m_axi_arburst (arburst),
    .o_wire_m_axi_arvalid (arvalid),
    .i_wire_m_axi_arready (arready),
    .i_wire_m_axi_rdata   (rdata),
    .i_wire_m_axi_rresp   (rresp),
    .i_wire_m_axi_rlast   (rlast),
    .i_wire_m_axi_rvalid  (rvalid),
    .o_wire_m_axi_rready  (rready),
    .o_wire_fifo_wr_en    (wr_en),
    .o_wire_fifo_wr_data  (wr_data),
    .i_wire_fifo_full     (fifo_full),
    .o_wire_state         (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  // AXI slave + FIFO monitor: samples on the falling edge, drives 1 time unit after rise.
  initial begin : slave
    bit          hs_ar, hs_r, arv_s, prev_pending;
    logic [31:0] ar_a, prev_a, r_addr;
    logic [7:0]  ar_l, prev_l;
    int          r_left, beat_idx, stall_left;
    hs_ar = 0; hs_r = 0; arv_s = 0; prev_pending = 0;
    ar_a = 0; ar_l = 0; prev_a = 0; prev_l = 0; r_addr = 0;
    r_left = 0; beat_idx = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pushes.delete(); ar_addrs.delete(); ar_lens.delete();
        last_push_cyc = -1; done_cyc = -1; error_cyc = -1;
        full_viol = 0; ar_unstable = 0; stall_seen = 0; arvalid_ever = 0;
        hs_ar = 0; hs_r = 0; arv_s = 0; prev_pending = 0;
        r_left = 0; beat_idx = 0; stall_left = stall_len;
      end else begin
        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        arv_s = arvalid;
        ar_a  = araddr;
        ar_l  = arlen;
        if (arvalid) arvalid_ever = 1;
        if (arvalid && prev_pending && (araddr != prev_a || arlen != prev_l)) ar_unstable++;
        prev_pending = arvalid && !arready;
        prev_a = araddr;
        prev_l = arlen;
        if (hs_ar) begin
          ar_addrs.push_back(araddr);
          ar_lens.push_back(arlen);
        end
        if (wr_en) begin
          pushes.push_back(wr_data);
          last_push_cyc = cyc;
        end
        if (fifo_full && rready) full_viol++;
        if (fifo_full && rvalid) stall_seen++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (error && error_cyc < 0) error_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (hs_ar) begin
          r_addr = ar_a;
          r_left = int'(ar_l) + 1;
        end
        if (hs_r) begin
          r_left--;
          r_addr += 32'd4;
          beat_idx++;
        end
      end else begin
        r_left = 0;
      end
      arready = ar_wait ? (arv_s && !hs_ar) : 1'b1;
      rvalid  = (r_left > 0);
      rdata   = rvalid ? pattern(r_addr) : 32'd0;
      rlast   = (r_left == 1);
      rresp   = (rvalid && beat_idx == err_beat) ? 2'b10 : 2'b00;
      if (rvalid && beat_idx == stall_beat && stall_left > 0) begin
        fifo_full = 1'b1;
        stall_left--;
      end else begin
        fifo_full = 1'b0;
      end
    end
  end

  // Hold reset long enough for the slave to clear, then release just after a falling edge.
  task automatic start(input logic [31:0] a, input logic [31:0] l);
    rst_n  = 1'b0;
    i_addr = a;
    i_len  = l;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_term(input int bound);
    int n;
    n = 0;
    while (!(done || error) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if (!(done || error)) begin
      tests_failed++;
      $display("FAIL terminate: done=%0b error=%0b after %0d cycles, required done|error", done,
               error, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({done, error, arvalid, rready, wr_en} !== 5'b0 || araddr !== 32'd0 || arlen !== 8'd0 ||
        wr_data !== 32'd0 || state !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: done=%0b err=%0b arv=%0b rr=%0b we=%0b araddr=%h arlen=%h st=%h, required all 0",
               done, error, arvalid, rready, wr_en, araddr, arlen, state);
    end
    tests_run++;
    if (arsize !== 3'b010 || arburst !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_consts: arsize=%b arburst=%b, required 010 01", arsize, arburst);
    end
  endtask

  task automatic test_single_burst();
    int bad;
    start(32'h1000, 32'd32);
    wait_term(200);
    tests_run++;
    if (ar_addrs.size() != 1 || ar_addrs[0] !== 32'h1000 || ar_lens[0] !== 8'd7) begin
      tests_failed++;
      $display("FAIL single_ar: count=%0d addr=%h len=%0d, required 1 1000 7", ar_addrs.size(),
               ar_addrs.size() > 0 ? ar_addrs[0] : 32'hx, ar_lens.size() > 0 ? ar_lens[0] : 8'hx);
    end
    bad = (pushes.size() == 8) ? 0 : 1;
    for (int i = 0; i < pushes.size() && i < 8; i++)
      if (pushes[i] !== pattern(32'h1000 + 32'(4 * i))) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL single_data: pushes=%0d bad=%0d, required 8 pushes 0 bad", pushes.size(), bad);
    end
    // Last beat accepted at edge k; done registers at edge k+1 (two falling-edge samples on).
    tests_run++;
    if (done !== 1'b1 || error !== 1'b0 || done_cyc - last_push_cyc != 2) begin
      tests_failed++;
      $display("FAIL single_done: done=%0b error=%0b delay=%0d, required 1 0 2", done, error,
               done_cyc - last_push_cyc);
    end
  endtask

  task automatic test_boundary_split();
    int bad;
    start(32'h0FF8, 32'd64);
    wait_term(300);
    tests_run++;
    if (ar_addrs.size() != 2 || ar_addrs[0] !== 32'h0FF8 || ar_lens[0] !== 8'd1 ||
        ar_addrs[1] !== 32'h1000 || ar_lens[1] !== 8'd13) begin
      tests_failed++;
      $display("FAIL split_ar: count=%0d, required 2 bursts 0FF8/1 1000/13", ar_addrs.size());
    end
    bad = (pushes.size() == 16) ? 0 : 1;
    for (int i = 0; i < pushes.size() && i < 16; i++)
      if (pushes[i] !== pattern(32'h0FF8 + 32'(4 * i))) bad++;
    tests_run++;
    if (bad != 0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL split_data: pushes=%0d bad=%0d done=%0b, required 16 0 1", pushes.size(),
               bad, done);
    end
  endtask

  task automatic test_max_burst();
    start(32'h2000, 32'd128);
    ar_wait = 1'b1;
    wait_term(400);
    tests_run++;
    if (ar_addrs.size() != 2 || ar_addrs[0] !== 32'h2000 || ar_lens[0] !== 8'd15 ||
        ar_addrs[1] !== 32'h2040 || ar_lens[1] !== 8'd15) begin
      tests_failed++;
      $display("FAIL max_ar: count=%0d, required 2 bursts 2000/15 2040/15", ar_addrs.size());
    end
    tests_run++;
    if (ar_unstable != 0 || pushes.size() != 32 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL max_hold: unstable=%0d pushes=%0d done=%0b, required 0 32 1", ar_unstable,
               pushes.size(), done);
    end
    ar_wait = 1'b0;
  endtask

  task automatic test_zero_length();
    start(32'h3000, 32'd0);
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || state !== 32'h3) begin
      tests_failed++;
      $display("FAIL zero_edge1: done=%0b state=%h, required 0 03", done, state);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_edge2: done=%0b error=%0b, required 1 0", done, error);
    end
    repeat (5) @(negedge clk);
    #2;
    tests_run++;
    if (arvalid_ever !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_noar: arvalid_seen=%0b, required 0", arvalid_ever);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs[2];
    logic [31:0] lens[2];
    addrs[0] = 32'h1000; lens[0] = 32'd6;
    addrs[1] = 32'h1002; lens[1] = 32'd32;
    for (int i = 0; i < 2; i++) begin
      start(addrs[i], lens[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (error !== 1'b0 || state !== 32'h4) begin
        tests_failed++;
        $display("FAIL misalign_edge1[%0d]: error=%0b state=%h, required 0 04", i, error, state);
      end
      repeat (6) @(negedge clk);
      #2;
      tests_run++;
      if (error !== 1'b1 || done !== 1'b0 || arvalid_ever !== 1'b0) begin
        tests_failed++;
        $display("FAIL misalign[%0d]: error=%0b done=%0b ar_seen=%0b, required 1 0 0", i, error,
                 done, arvalid_ever);
      end
    end
  endtask

  task automatic test_fifo_full();
    int bad;
    stall_beat = 2;
    stall_len  = 3;
    start(32'h1000, 32'd32);
    wait_term(200);
    tests_run++;
    if (full_viol != 0 || stall_seen != 3) begin
      tests_failed++;
      $display("FAIL full_rready: viol=%0d stalled=%0d, required 0 3", full_viol, stall_seen);
    end
    bad = (pushes.size() == 8) ? 0 : 1;
    for (int i = 0; i < pushes.size() && i < 8; i++)
      if (pushes[i] !== pattern(32'h1000 + 32'(4 * i))) bad++;
    tests_run++;
    if (bad != 0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_data: pushes=%0d bad=%0d done=%0b, required 8 0 1", pushes.size(), bad,
               done);
    end
    stall_beat = -1;
    stall_len  = 0;
  endtask

  task automatic test_rresp_error();
    int bad;
    err_beat = 3;
    start(32'h1000, 32'd32);
    wait_term(200);
    bad = (pushes.size() == 4) ? 0 : 1;
    for (int i = 0; i < pushes.size() && i < 4; i++)
      if (pushes[i] !== pattern(32'h1000 + 32'(4 * i))) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rresp_pushes: pushes=%0d bad=%0d, required 4 0", pushes.size(), bad);
    end
    tests_run++;
    if (error !== 1'b1 || done !== 1'b0 || state !== 32'h4 || error_cyc - last_push_cyc != 2) begin
      tests_failed++;
      $display("FAIL rresp_error: error=%0b done=%0b state=%h delay=%0d, required 1 0 04 2", error,
               done, state, error_cyc - last_push_cyc);
    end
    tests_run++;
    if (rready !== 1'b0 || arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rresp_quiet: rready=%0b arvalid=%0b, required 0 0", rready, arvalid);
    end
    err_beat = -1;
  endtask

  task automatic test_reset_mid_data();
    int n;
    start(32'h1000, 32'd32);
    n = 0;
    while (pushes.size() < 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    tests_run++;
    if (state !== 32'h2) begin
      tests_failed++;
      $display("FAIL midreset_pre: state=%h pushes=%0d, required 02", state, pushes.size());
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({done, error, arvalid, rready, wr_en} !== 5'b0 || araddr !== 32'd0 || arlen !== 8'd0 ||
        wr_data !== 32'd0 || state !== 32'd0 || arsize !== 3'b010 || arburst !== 2'b01) begin
      tests_failed++;
      $display("FAIL midreset: done=%0b err=%0b arv=%0b rr=%0b we=%0b araddr=%h arlen=%h st=%h, required reset values",
               done, error, arvalid, rready, wr_en, araddr, arlen, state);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_boundary_split();
    test_max_burst();
    test_zero_length();
    test_misaligned();
    test_fifo_full();
    test_rresp_error();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_reader.md
# painterengine_gpu_dma_reader

AXI4 read master that fetches a contiguous word-aligned memory region and pushes each 32-bit word into the GPU copy FIFO. It sits directly downstream of the memcpy controller: that controller drives this block's reset, address and length per block, then waits for `o_wire_done` or `o_wire_error`. The DMA writer drains the same FIFO afterwards.

## Interface
Parameters:
- `MAX_BURST_BEATS`, default 16: maximum beats per AXI burst. Range 1..256.

Ports:
- `i_wire_clock`  in  1  clock.
- `i_wire_resetn`  in  1  reset, asynchronous, active-low. Connected to the controller's per-block reader reset; its release starts one transfer.
- `i_wire_address`  in  32  start byte address. Must be word-aligned.
- `i_wire_length`  in  32  byte count. Must be a multiple of 4; 0 is legal.
- `o_wire_done`  out  1  transfer complete. Sticky until reset.
- `o_wire_error`  out  1  transfer failed. Sticky until reset.
- `o_wire_m_axi_araddr`  out  32  burst start address.
- `o_wire_m_axi_arlen`  out  8  beats−1.
- `o_wire_m_axi_arsize`  out  3  constant 3'b010.
- `o_wire_m_axi_arburst`  out  2  constant 2'b01 (INCR).
- `o_wire_m_axi_arvalid`  out  1  AR valid.
- `i_wire_m_axi_arready`  in  1  AR ready.
- `i_wire_m_axi_rdata`  in  32  read data.
- `i_wire_m_axi_rresp`  in  2  read response.
- `i_wire_m_axi_rlast`  in  1  last beat.
- `i_wire_m_axi_rvalid`  in  1  R valid.
- `o_wire_m_axi_rready`  out  1  R ready.
- `o_wire_fifo_wr_en`  out  1  FIFO push strobe.
- `o_wire_fifo_wr_data`  out  32  FIFO push data.
- `i_wire_fifo_full`  in  1  FIFO full.
- `o_wire_state`  out  32  `{24'd0, state}` for debug.

## Operation
States are `INIT` 0x00, `ADDR` 0x01, `DATA` 0x02, `DONE` 0x03, and `ERROR` 0x04.
- `INIT`: latch address and length.
  - Low 2 bits of address or length nonzero: go to `ERROR`.
  - Length 0: go to `DONE`.
  - Otherwise: remaining words = length>>2; go to `ADDR`.
- `ADDR`: burst beats = min(remaining words, `MAX_BURST_BEATS`, words to the next 4 KB boundary).
  - The 4 KB term is (4096 − addr[11:0])>>2.
  - Drive arvalid with araddr = current address and arlen = beats−1. Hold all AR fields stable until arready.
  - On handshake: load the beat counter and go to `DATA`.
- `DATA`: rready = !i_wire_fifo_full.
  - On each rvalid&&rready: push rdata (wr_en=1, wr_data=rdata) and decrement the beat counter.
  - rresp != 2'b00: go to `ERROR`. The failing beat is still pushed.
  - rlast on a beat that is not the last, or rlast missing on the last beat: go to `ERROR`.
  - Final beat: address += beats×4; remaining −= beats. Remaining 0 goes to `DONE`, else to `ADDR`.
- `DONE` and `ERROR` are terminal. arvalid=0, rready=0. Only reset leaves them.
- All address and length arithmetic is 32-bit unsigned. Address wrap past 0xFFFFFFFC is not guarded; the controller never issues it.

## Timing
- Reset values: every output 0 except arsize=3'b010 and arburst=2'b01. State = `INIT`.
- Address and length are sampled on the first rising edge after reset release. They are ignored afterwards.
- `INIT` → `ADDR` takes 1 cycle. arvalid rises on the 2nd edge after reset release.
- One burst outstanding at a time; no AR is issued until the previous burst's last beat completes.
- FIFO push is combinational with the R handshake: wr_en = rvalid && rready in `DATA`. Zero-latency.
- FIFO full with rvalid=1: rready=0 and no push. Beats are never dropped or duplicated.
- `o_wire_done` and `o_wire_error` are registered. They assert 1 cycle after the final beat, or after the error beat or `INIT` check, and hold until reset.
- Reset mid-burst: asynchronous clear to reset values; the AXI burst is abandoned. The controller only resets this block after done or error, so this case is out of contract for the interconnect.

## Structure
- Shared package or header `painterengine_gpu_dma_defs`: state encodings, AXI constants (OKAY, INCR, SIZE_4B), and the 4 KB boundary constant. The DMA writer reuses it.
- No sub-module is required. The burst-size min() is an inline function.

## Test plan
- Address 0x1000, length 32, MAX 16, slave zero-wait: one AR with arlen=7; 8 FIFO pushes in order; done=1 one cycle after the 8th beat; error=0.
- Address 0x0FF8, length 64: first AR at 0x0FF8 with arlen=1, second AR at 0x1000 with arlen=13; 16 pushes; done.
- Length 0: done=1 on the 2nd edge after reset release; arvalid never asserts.
- Length 6 or address 0x1002: error=1 and state=0x04; no AR issued.
- Length 32 with i_wire_fifo_full held high on beats 3–5: rready low in those cycles; exactly 8 pushes with correct data; done.
- Length 32 with rresp=2'b10 on beat 4: error=1 one cycle later; done stays 0. Then a reset pulse mid-`DATA` on a fresh run: all outputs return to reset values immediately.
